// File: rtl/ahb_lcd_seq_if.sv
// AHB-Lite slave-side bus bundle for ahb_lcd_seq.
// The master modport is the interconnect/CPU view; the slave modport is the peripheral view.
interface ahb_lcd_seq_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_lcd_seq.sv
// AHB-Lite slave driving an 8080-style 16-bit LCD write bus from a command/data FIFO.
// Optional feature macro LCD_FILL_EN adds FILL_VAL (0x10) / FILL_CNT (0x14) hardware fill.
module ahb_lcd_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int WR_LO_RST  = 1,
    parameter int WR_HI_RST  = 1
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_lcd_seq_if.slave bus,
    output logic         LCD_CS,
    output logic         LCD_RS,
    output logic         LCD_WR,
    output logic         LCD_RD,
    output logic         LCD_RST,
    output logic         LCD_BL_CTR,
    output logic [15:0]  LCD_DATA,
    output logic [1:0]   o_dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRLO, S_WRHI} state_t;

    state_t        r_state;
    logic          r_dp_valid, r_dp_write;
    logic [5:0]    r_dp_addr;
    logic [16:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_ctrl_rst, r_ctrl_bl;
    logic [3:0]    r_ctrl_lo, r_ctrl_hi, r_lo_cur, r_hi_cur, r_cnt;
    logic          r_cs, r_wr, r_rs;
    logic [15:0]   r_data;

    logic          w_wr_phase, w_push_req, w_push, w_pop, w_take, w_next_go;
    logic          w_full, w_empty, w_fill_active, w_busy;
    logic [16:0]   w_head, w_load;
    logic [31:0]   w_stat, w_rdata;
    logic          w_unused;

    // Address phase is captured only when the bus is ready; a stalled push holds it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
        end else if (bus.HREADY) begin
            r_dp_valid <= bus.HSEL & bus.HTRANS[1];
            r_dp_write <= bus.HWRITE;
            r_dp_addr  <= bus.HADDR[7:2];
        end
    end

    assign w_wr_phase    = r_dp_valid & r_dp_write;
    assign w_push_req    = w_wr_phase & ((r_dp_addr == 6'd0) | (r_dp_addr == 6'd1));
    assign w_full        = (r_level == LW'(FIFO_DEPTH));
    assign w_empty       = (r_level == '0);
    assign w_head        = r_mem[r_rptr];
    assign w_next_go     = (r_state == S_IDLE) | ((r_state == S_WRHI) & (r_cnt == r_hi_cur));
    assign w_pop         = w_next_go & ~w_fill_active & ~w_empty;
    assign w_take        = w_next_go & (w_fill_active | ~w_empty);
    assign w_push        = w_push_req & (~w_full | w_pop);
    assign bus.HREADYOUT = ~(w_push_req & w_full & ~w_pop);
    assign bus.HRESP     = 1'b0;

    always_ff @(posedge HCLK) begin
        if (w_push) r_mem[r_wptr] <= {r_dp_addr[0], bus.HWDATA[15:0]};
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_ctrl_rst <= 1'b0;
            r_ctrl_bl  <= 1'b0;
            r_ctrl_lo  <= 4'(WR_LO_RST);
            r_ctrl_hi  <= 4'(WR_HI_RST);
        end else if (w_wr_phase && r_dp_addr == 6'd2) begin
            r_ctrl_rst <= bus.HWDATA[0];
            r_ctrl_bl  <= bus.HWDATA[1];
            r_ctrl_lo  <= bus.HWDATA[7:4];
            r_ctrl_hi  <= bus.HWDATA[11:8];
        end
    end

`ifdef LCD_FILL_EN
    logic [15:0] r_fill_val;
    logic [23:0] r_fill_cnt;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_fill_val <= '0;
            r_fill_cnt <= '0;
        end else begin
            if (w_wr_phase && r_dp_addr == 6'd4) r_fill_val <= bus.HWDATA[15:0];
            // A fill may only start from a fully quiet engine; otherwise the count is dropped.
            if (w_wr_phase && r_dp_addr == 6'd5 && bus.HWDATA[23:0] != 24'd0 &&
                r_state == S_IDLE && w_empty && r_fill_cnt == 24'd0)
                r_fill_cnt <= bus.HWDATA[23:0];
            else if (w_take && w_fill_active)
                r_fill_cnt <= r_fill_cnt - 24'd1;
        end
    end

    assign w_fill_active = (r_fill_cnt != 24'd0);
    assign w_load        = w_fill_active ? {1'b1, r_fill_val} : w_head;
`else
    assign w_fill_active = 1'b0;
    assign w_load        = w_head;
`endif

    // Word period: SETUP (1) + WRLO (lo+1) + WRHI (hi+1); CS stays low across a burst.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_cs     <= 1'b1;
            r_wr     <= 1'b1;
            r_rs     <= 1'b0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_lo_cur <= 4'(WR_LO_RST);
            r_hi_cur <= 4'(WR_HI_RST);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_SETUP;
                        r_cs    <= 1'b0;
                        r_rs    <= w_load[16];
                        r_data  <= w_load[15:0];
                    end
                end
                S_SETUP: begin
                    r_lo_cur <= r_ctrl_lo;
                    r_hi_cur <= r_ctrl_hi;
                    r_wr     <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_WRLO;
                end
                S_WRLO: begin
                    if (r_cnt == r_lo_cur) begin
                        r_wr    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WRHI;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WRHI: begin
                    if (r_cnt == r_hi_cur) begin
                        if (w_take) begin
                            r_state <= S_SETUP;
                            r_rs    <= w_load[16];
                            r_data  <= w_load[15:0];
                        end else begin
                            r_state <= S_IDLE;
                            r_cs    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_busy = (r_state != S_IDLE) | ~w_empty | w_fill_active;

    always_comb begin
        w_stat = '0;
        w_stat[0] = w_busy;
        w_stat[1] = w_full;
        w_stat[2] = w_empty;
        w_stat[8 +: LW] = r_level;
    end

    always_comb begin
        w_rdata = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                6'd2: w_rdata = {20'd0, r_ctrl_hi, r_ctrl_lo, 2'b00, r_ctrl_bl, r_ctrl_rst};
                6'd3: w_rdata = w_stat;
`ifdef LCD_FILL_EN
                6'd4: w_rdata = {16'd0, r_fill_val};
                6'd5: w_rdata = {8'd0, r_fill_cnt};
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.HRDATA = w_rdata;
    assign LCD_CS     = r_cs;
    assign LCD_WR     = r_wr;
    assign LCD_RD     = 1'b1;
    assign LCD_RS     = r_rs;
    assign LCD_DATA   = r_data;
    assign LCD_RST    = r_ctrl_rst;
    assign LCD_BL_CTR = r_ctrl_bl;
    assign o_dbg_state = r_state;

    assign w_unused = ^{bus.HADDR[31:8], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE,
                        bus.HPROT, bus.HWDATA[31:16]};
endmodule

// File: tb/tb_ahb_lcd_seq.sv
// Self-checking bench for ahb_lcd_seq: AHB driver tasks, a pin monitor and an expected-word queue.
// Define LCD_FILL_EN for both this file and the RTL to exercise the fill feature.
module tb_ahb_lcd_seq;
    localparam int DEPTH = 8;
    localparam logic [7:0] A_CMD = 8'h00, A_DAT = 8'h04, A_CTRL = 8'h08, A_STAT = 8'h0C;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_bl;
    logic [15:0] lcd_data;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    ahb_lcd_seq_if u_if();
    assign u_if.HREADY = u_if.HREADYOUT;

    ahb_lcd_seq #(.FIFO_DEPTH(DEPTH), .WR_LO_RST(1), .WR_HI_RST(1)) u_dut (
        .HCLK(clk), .HRESETn(rstn), .bus(u_if),
        .LCD_CS(lcd_cs), .LCD_RS(lcd_rs), .LCD_WR(lcd_wr), .LCD_RD(lcd_rd),
        .LCD_RST(lcd_rst), .LCD_BL_CTR(lcd_bl), .LCD_DATA(lcd_data),
        .o_dbg_state(dbg_state)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [16:0] exp_q[$];
    int          exp_lo = 1;
    int          exp_hi = 1;
    int          rises = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Pin monitor: every WR rise is one word, whose value, pulse width and burst length
    // are set against the queue and the timing formula.
    logic        mon_prev_wr = 1'b1, mon_prev_cs = 1'b1;
    int          mon_lo_cnt = 0, mon_cs_cnt = 0, mon_words = 0;
    logic [16:0] mon_fall_word = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            mon_prev_wr = 1'b1;
            mon_prev_cs = 1'b1;
            mon_lo_cnt  = 0;
            mon_cs_cnt  = 0;
            mon_words   = 0;
        end else begin
            if (!lcd_cs) mon_cs_cnt++;
            if (!lcd_wr) begin
                if (mon_prev_wr) begin
                    mon_lo_cnt = 0;
                    mon_fall_word = {lcd_rs, lcd_data};
                    check("cs_low_at_wr_fall", {31'd0, lcd_cs}, 32'd0);
                end
                mon_lo_cnt++;
            end
            if (lcd_wr && !mon_prev_wr) begin
                check("wr_low_len", mon_lo_cnt, exp_lo + 1);
                check("word_stable", {15'd0, lcd_rs, lcd_data}, {15'd0, mon_fall_word});
                check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("word", {15'd0, lcd_rs, lcd_data}, {15'd0, exp_q.pop_front()});
                mon_words++;
                rises++;
            end
            if (lcd_cs && !mon_prev_cs) begin
                check("cs_low_len", mon_cs_cnt, mon_words * (3 + exp_lo + exp_hi));
                mon_cs_cnt = 0;
                mon_words  = 0;
            end
            mon_prev_wr = lcd_wr;
            mon_prev_cs = lcd_cs;
        end
    end

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, output logic stalled);
        int n;
        @(negedge clk);
        u_if.HSEL = 1'b1; u_if.HTRANS = 2'b10; u_if.HWRITE = 1'b1; u_if.HADDR = {24'd0, a};
        @(negedge clk);
        u_if.HSEL = 1'b0; u_if.HTRANS = 2'b00; u_if.HWDATA = d;
        n = 0;
        while (u_if.HREADYOUT !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("hready_timeout", n, 0);
        stalled = (n != 0);
    endtask

    task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        u_if.HSEL = 1'b1; u_if.HTRANS = 2'b10; u_if.HWRITE = 1'b0; u_if.HADDR = {24'd0, a};
        @(negedge clk);
        u_if.HSEL = 1'b0; u_if.HTRANS = 2'b00;
        d = u_if.HRDATA;
    endtask

    task automatic push(input logic rs, input logic [15:0] v, output logic stalled);
        exp_q.push_back({rs, v});
        ahb_write(rs ? A_DAT : A_CMD, {16'd0, v}, stalled);
    endtask

    task automatic set_ctrl(input logic rst, input logic bl, input int lo, input int hi);
        logic        st;
        logic [31:0] rd;
        logic [31:0] val;
        val = {20'd0, 4'(hi), 4'(lo), 2'b00, bl, rst};
        ahb_write(A_CTRL, val, st);
        exp_lo = lo;
        exp_hi = hi;
        @(negedge clk);
        check("lcd_rst_pin", {31'd0, lcd_rst}, {31'd0, rst});
        check("lcd_bl_pin", {31'd0, lcd_bl}, {31'd0, bl});
        ahb_read(A_CTRL, rd);
        check("ctrl_readback", rd, val);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int polls = 0;
        do begin
            ahb_read(A_STAT, s);
            polls++;
        end while (s[0] && polls < 3000);
        check("stat_idle", s, 32'h0000_0004);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rises < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("rise_timeout", rises, target);
    endtask

    task automatic check_reset_pins();
        logic [31:0] rd;
        check("rst_cs", {31'd0, lcd_cs}, 32'd1);
        check("rst_wr", {31'd0, lcd_wr}, 32'd1);
        check("rst_rd", {31'd0, lcd_rd}, 32'd1);
        check("rst_rstpin", {31'd0, lcd_rst}, 32'd0);
        check("rst_bl", {31'd0, lcd_bl}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_data", {16'd0, lcd_data}, 32'd0);
        check("rst_hreadyout", {31'd0, u_if.HREADYOUT}, 32'd1);
        check("hresp", {31'd0, u_if.HRESP}, 32'd0);
        ahb_read(A_STAT, rd);
        check("rst_stat", rd, 32'h0000_0004);
        ahb_read(A_CTRL, rd);
        check("rst_ctrl", rd, 32'h0000_0110);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic        st;
        logic [31:0] rd;
        int          base, nw, lo, hi;

        u_if.HSEL = 1'b0; u_if.HADDR = '0; u_if.HTRANS = 2'b00; u_if.HSIZE = 3'b010;
        u_if.HPROT = 4'b0011; u_if.HWRITE = 1'b0; u_if.HWDATA = '0;

        // clock/reset
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_reset_pins();

        // two-word burst at minimum timing
        set_ctrl(1'b1, 1'b1, 0, 0);
        push(1'b0, 16'h002C, st);
        push(1'b1, 16'h1234, st);
        wait_idle();

        // long WR-low, short WR-high
        set_ctrl(1'b1, 1'b1, 3, 0);
        for (int i = 0; i < 3; i++) push(1'b1, 16'($urandom), st);
        wait_idle();

        // overfill: only the (DEPTH+2)-th write has to wait for a pop
        set_ctrl(1'b0, 1'b1, 15, 15);
        for (int i = 1; i <= DEPTH + 2; i++) begin
            push(1'b1, 16'($urandom), st);
            check($sformatf("stall_w%0d", i), {31'd0, st}, {31'd0, i == DEPTH + 2});
        end
        ahb_read(A_STAT, rd);
        check("stat_full", rd, (32'(DEPTH) << 8) | 32'h3);
        wait_idle();

        // FIFO level seen through STAT as the burst proceeds
        set_ctrl(1'b1, 1'b0, 15, 15);
        base = rises;
        for (int i = 0; i < 6; i++) push(1'b1, 16'($urandom), st);
        for (int k = 1; k <= 3; k++) begin
            wait_rises(base + k);
            ahb_read(A_STAT, rd);
            check($sformatf("stat_level_k%0d", k), rd, (32'(6 - k) << 8) | 32'h1);
        end
        wait_idle();

        // randomized timing and traffic
        for (int it = 0; it < 6; it++) begin
            lo = $urandom_range(0, 3);
            hi = $urandom_range(0, 3);
            set_ctrl(1'($urandom), 1'($urandom), lo, hi);
            nw = $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) push(1'($urandom), 16'($urandom), st);
            wait_idle();
        end

        // reset in the middle of a burst aborts and flushes
        set_ctrl(1'b1, 1'b1, 2, 2);
        base = rises;
        for (int i = 0; i < 5; i++) push(1'b1, 16'($urandom), st);
        wait_rises(base + 2);
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        exp_lo = 1;
        exp_hi = 1;
        @(negedge clk);
        check_reset_pins();
        push(1'b0, 16'h00A5, st);
        push(1'b1, 16'h5A5A, st);
        wait_idle();

        // unmapped offsets
        ahb_write(8'h18, 32'hFFFF_FFFF, st);
        ahb_read(8'h18, rd);
        check("unmapped_read", rd, 32'd0);
        ahb_read(A_CTRL, rd);
        check("ctrl_untouched", rd, 32'h0000_0110);

`ifdef LCD_FILL_EN
        ahb_write(8'h10, 32'h0000_F800, st);
        ahb_read(8'h10, rd);
        check("fill_val_rb", rd, 32'h0000_F800);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 16'hF800});
        ahb_write(8'h14, 32'd5, st);
        push(1'b0, 16'h0029, st);
        wait_idle();
        ahb_read(8'h14, rd);
        check("fill_cnt_done", rd, 32'd0);
`else
        ahb_write(8'h10, 32'h0000_F800, st);
        ahb_read(8'h10, rd);
        check("fill_val_absent", rd, 32'd0);
        ahb_write(8'h14, 32'd5, st);
        repeat (4) @(negedge clk);
        check("fill_no_activity", {31'd0, lcd_cs}, 32'd1);
        ahb_read(8'h14, rd);
        check("fill_cnt_absent", rd, 32'd0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
